sprite_update_tracker: RTL
==========================

# sprite_update_tracker

Snoops CPU writes to the sprite-position and sprite-number registers and turns each completed position write (x then y) into one update request for `collision_fsm`. It queues requests while that FSM is busy, presents one candidate position at a time, and commits the candidate only if the FSM does not assert `restore` for it. It sits directly upstream of `collision_fsm` and drives its `sprite_update`, `update_index`, `sprite_num`, `sprite_x`/`sprite_y` and `sprite_row`/`sprite_col` inputs.

## Interface
- No parameters; sizes are fixed constants in `sprite_pkg`.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `cpu_wr_en` input 1: CPU write strobe, one cycle per write.
- `cpu_addr` input 16: CPU write address.
- `cpu_wdata` input 8: CPU write data.
- `fsm_busy` input 1: `cpu_pause` from `collision_fsm`.
- `restore` input 8: per-sprite reject from `collision_fsm`.
- `sprite_update` output 1: one-cycle request pulse.
- `update_index` output 3: sprite index of the presented candidate.
- `sprite_num` output 6: sprite code of that sprite (register bits [7:2]).
- `sprite_x`, `sprite_y` output [7:0][7:0]: committed (last accepted) position per sprite.
- `sprite_row`, `sprite_col` output 8: candidate y and x.
- `queue_overflow` output 1: sticky flag, set when a request is dropped.

## Operation
- Decode, only when `cpu_wr_en`=1:
  - `0x5060+2i` writes the x register of sprite i; it loads `pend_x[i]`.
  - `0x5061+2i` writes the y register of sprite i; it enqueues {i, `pend_x[i]`, `cpu_wdata`}.
  - `0x4FF0+2i` loads `num[i]` from `cpu_wdata[7:2]`.
  - All other addresses are ignored.
- A y write with no preceding x write uses the current `pend_x[i]` (reset value 0).
- Each queue entry holds {index[2:0], x[7:0], y[7:0]}.
- State machine, one state per line:
  - IDLE: go to ISSUE when the queue is non-empty and `fsm_busy`=0.
  - ISSUE: present the head entry for exactly 1 cycle and assert `sprite_update`.
    - If `fsm_busy` is sampled 1 in this cycle, go to WAIT.
    - If it is sampled 0 (the sprite is neither pacman nor ghost, so the FSM ignores it), commit, pop, and return to IDLE.
  - WAIT: keep presenting the head entry. Set `rej` if `restore[head.index]`=1 in any cycle.
    - When `fsm_busy`=0: commit only if `rej`=0, then pop, clear `rej`, and return to IDLE.
- Commit: `sprite_x[idx]` ← entry x and `sprite_y[idx]` ← entry y. A rejected candidate leaves the committed values unchanged; this is the value `collision_fsm` writes back.
- `sprite_row`/`sprite_col` show the head entry's y/x in ISSUE and WAIT, and hold their last values otherwise.
- `update_index` and `sprite_num` track the head entry while ISSUE or WAIT.
- A CPU write while `fsm_busy`=1 is still captured. The CPU bus is paused upstream, so such a write normally does not occur.
- Push and pop in the same cycle are both honoured and the occupancy count stays unchanged.
- A push into a full queue drops the new entry and sets `queue_overflow`. Only `rst` clears the flag.

## Timing
- Reset: every output is 0, all pending/committed/num registers are 0, the queue is empty, and the state is IDLE.
- Minimum latency is 2 cycles from the y-write cycle to the `sprite_update` pulse: the write cycle enqueues and the following cycle is IDLE→ISSUE.
- Commit takes effect on the cycle after `fsm_busy` is sampled low in WAIT. It takes effect on the cycle after ISSUE when `fsm_busy` is low in ISSUE.
- Back-to-back requests are separated by at least one IDLE cycle.
- Reset asserted mid-operation discards the queue and any request in flight immediately. No commit happens.

## Configuration
- `SPRITE_UPDATE_QUEUE_EN` defined: the queue is 4 entries deep, in FIFO order.
- `SPRITE_UPDATE_QUEUE_EN` undefined: the queue is a single slot, and `queue_overflow` is tied to 0.
  - A push while the slot holds an entry not yet issued overwrites it (latest position wins).
  - A push while the slot's entry is in ISSUE or WAIT is held in a 1-entry skid register. It loads the slot on pop.
  - A second push into an occupied skid register overwrites it.

## Structure
- `sprite_pkg` holds:
  - `SPR_POS_BASE` = 0x5060
  - `SPR_NUM_BASE` = 0x4FF0
  - `NUM_SPRITES` = 8
  - `UPD_Q_DEPTH` = 4
  - typedef `spr_upd_t` (index, x, y)
  - enum `tracker_state_t` (IDLE, ISSUE, WAIT)
- Sub-module `spr_upd_fifo`: a synchronous FIFO of `spr_upd_t` with push/pop/full/empty and an asynchronous reset.

## Test plan
- After reset, write x=0x40 then y=0x50 to sprite 2 with `fsm_busy` held 0. Required: `sprite_update` pulses 2 cycles after the y write with index 2, row 0x50, col 0x40, and `sprite_x[2]`=0x40, `sprite_y[2]`=0x50 one cycle later.
- Set sprite 0's committed position to (0x40, 0x50) using the previous scenario's sequence, then write (0x41, 0x50) to sprite 0. Hold `fsm_busy`=1 for 6 cycles from ISSUE and pulse `restore[0]` in cycle 2. Required: `sprite_x[0]` stays 0x40 and the queue is empty afterwards.
- Same as above with no `restore`. Required: `sprite_x[0]`=0x41 one cycle after `fsm_busy` falls.
- Write sprite_num register `0x4FF6` = 0xB4, then a position for sprite 3. Required: `sprite_num`=45 during ISSUE.
- With `fsm_busy` held 1, issue 5 y-writes for sprites 0..4. Required with the macro defined: `queue_overflow`=1, and after release the pulses appear for sprites 0..3 only, in order.
- Assert `rst` during WAIT. Required: all outputs are 0 next cycle and no commit occurs.

Source files
------------

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants and types for the sprite update tracker
//
// Holds the CPU register map bases, sprite count, request queue depth,
// the queued request record and the tracker state encoding.

package sprite_pkg;

    localparam logic [15:0] SPR_POS_BASE = 16'h5060;
    localparam logic [15:0] SPR_NUM_BASE = 16'h4FF0;
    localparam int          NUM_SPRITES  = 8;
    localparam int          UPD_Q_DEPTH  = 4;

    // One position update request: which sprite, and its candidate x/y.
    typedef struct packed {
        logic [2:0] index;
        logic [7:0] x;
        logic [7:0] y;
    } spr_upd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } tracker_state_t;

endpackage

// File: rtl/spr_upd_fifo.sv
// rtl/spr_upd_fifo.sv - synchronous FIFO of sprite update requests
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push_i, din_i   write strobe and request to enqueue
//   pop_i           remove the head entry
//   head_o          current head entry (valid when empty_o = 0)
//   full_o, empty_o occupancy flags
//
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; with DEPTH = 1 that makes push+pop a plain replacement of the slot.

module spr_upd_fifo
    import sprite_pkg::*;
#(
    parameter int DEPTH = UPD_Q_DEPTH
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push_i,
    input  spr_upd_t din_i,
    input  logic     pop_i,
    output spr_upd_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    // Pointers keep at least one bit so DEPTH = 1 still has a legal width;
    // they wrap at DEPTH, so any slots above DEPTH-1 are never touched.
    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              SLOTS    = 1 << AW;
    localparam logic [AW-1:0]   LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);

    spr_upd_t      mem_q [SLOTS];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wrap_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= wrap_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: nothing reads it while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/sprite_update_tracker.sv
// rtl/sprite_update_tracker.sv - turns CPU sprite position writes into collision_fsm update requests
//
// Build option: SPRITE_UPDATE_QUEUE_EN
//   defined   - 4-deep FIFO of requests, drops and flags on overflow
//   undefined - single slot (latest unissued position wins) plus a 1-entry
//               skid register for writes arriving while a request is in flight
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_wr_en/addr/wdata     snooped CPU write bus
//   fsm_busy                 collision_fsm busy (cpu_pause)
//   restore[7:0]             per-sprite reject from collision_fsm
//   sprite_update            one-cycle request pulse
//   update_index, sprite_num index and code of the presented sprite
//   sprite_x, sprite_y       committed position per sprite
//   sprite_row, sprite_col   presented candidate y / x
//   queue_overflow           sticky dropped-request flag

module sprite_update_tracker
    import sprite_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_wr_en,
    input  logic [15:0]     cpu_addr,
    input  logic [7:0]      cpu_wdata,
    input  logic            fsm_busy,
    input  logic [7:0]      restore,
    output logic            sprite_update,
    output logic [2:0]      update_index,
    output logic [5:0]      sprite_num,
    output logic [7:0][7:0] sprite_x,
    output logic [7:0][7:0] sprite_y,
    output logic [7:0]      sprite_row,
    output logic [7:0]      sprite_col,
    output logic            queue_overflow
);

`ifdef SPRITE_UPDATE_QUEUE_EN
    localparam int Q_DEPTH = UPD_Q_DEPTH;
`else
    localparam int Q_DEPTH = 1;
`endif

    tracker_state_t                   state_q;
    spr_upd_t                         cur_q;
    logic                             rej_q;
    logic                             sprite_update_q;
    logic [NUM_SPRITES-1:0][7:0]      pend_x_q;
    logic [NUM_SPRITES-1:0][5:0]      num_q;
    logic [NUM_SPRITES-1:0][7:0]      sprite_x_q;
    logic [NUM_SPRITES-1:0][7:0]      sprite_y_q;

    // ---------------------------------------------------------------
    // CPU write decode
    // ---------------------------------------------------------------
    logic [15:0] pos_off;
    logic [15:0] num_off;
    logic [2:0]  pos_idx;
    logic [2:0]  num_idx;
    logic        x_wr;
    logic        y_wr;
    logic        num_wr;
    spr_upd_t    new_entry;

    always_comb begin
        pos_off   = cpu_addr - SPR_POS_BASE;
        num_off   = cpu_addr - SPR_NUM_BASE;
        pos_idx   = pos_off[3:1];
        num_idx   = num_off[3:1];
        x_wr      = cpu_wr_en && (pos_off[15:4] == 12'h000) && !pos_off[0];
        y_wr      = cpu_wr_en && (pos_off[15:4] == 12'h000) &&  pos_off[0];
        num_wr    = cpu_wr_en && (num_off[15:4] == 12'h000) && !num_off[0];
        new_entry = '{index: pos_idx, x: pend_x_q[pos_idx], y: cpu_wdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_x_q <= '0;
            num_q    <= '0;
        end else begin
            if (x_wr) begin
                pend_x_q[pos_idx] <= cpu_wdata;
            end
            if (num_wr) begin
                num_q[num_idx] <= cpu_wdata[7:2];
            end
        end
    end

    // ---------------------------------------------------------------
    // Request queue
    // ---------------------------------------------------------------
    logic     fifo_push;
    logic     fifo_pop;
    spr_upd_t fifo_din;
    spr_upd_t q_head;
    logic     q_full;
    logic     q_empty;

    spr_upd_fifo #(
        .DEPTH (Q_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .head_o  (q_head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // ---------------------------------------------------------------
    // Handshake decisions shared by queue and FSM
    // ---------------------------------------------------------------
    logic     in_idle;
    logic     launch;
    logic     finish;
    logic     commit;
    spr_upd_t launch_entry;

    always_comb begin
        in_idle = (state_q == IDLE);
        // Launch looks at occupancy before this cycle's push.
        launch  = in_idle && !q_empty && !fsm_busy;
        finish  = !in_idle && !fsm_busy;
        // A reject seen on the very cycle busy drops still counts.
        commit  = finish && !((state_q == WAIT) && (rej_q || restore[cur_q.index]));
    end

`ifdef SPRITE_UPDATE_QUEUE_EN
    logic ovf_q;

    always_comb begin
        fifo_push    = y_wr;
        fifo_pop     = finish;
        fifo_din     = new_entry;
        launch_entry = q_head;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (y_wr && q_full && !finish) begin
            ovf_q <= 1'b1;
        end
    end

    assign queue_overflow = ovf_q;
`else
    logic     skid_valid_q;
    spr_upd_t skid_q;

    // While idle, a write replaces the unissued slot (pop+push on a full
    // 1-deep FIFO). While a request is in flight, writes land in the skid
    // register, which refills the slot when the request retires.
    always_comb begin
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        fifo_din  = new_entry;
        if (in_idle) begin
            fifo_push = y_wr;
            fifo_pop  = y_wr && q_full;
        end else if (finish) begin
            fifo_pop  = 1'b1;
            fifo_push = y_wr || skid_valid_q;
            fifo_din  = y_wr ? new_entry : skid_q;
        end
        // A write in the launch cycle overwrites the slot, so present it.
        launch_entry = y_wr ? new_entry : q_head;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else if (finish) begin
            skid_valid_q <= 1'b0;
        end else if (y_wr && !in_idle) begin
            skid_valid_q <= 1'b1;
            skid_q       <= new_entry;
        end
    end

    assign queue_overflow = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Issue FSM and commit
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cur_q           <= '0;
            rej_q           <= 1'b0;
            sprite_update_q <= 1'b0;
            sprite_x_q      <= '0;
            sprite_y_q      <= '0;
        end else begin
            sprite_update_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        state_q         <= ISSUE;
                        sprite_update_q <= 1'b1;
                        cur_q           <= launch_entry;
                    end
                end
                ISSUE: begin
                    // Busy not raised means the FSM ignored this sprite.
                    state_q <= fsm_busy ? WAIT : IDLE;
                end
                WAIT: begin
                    if (fsm_busy) begin
                        if (restore[cur_q.index]) begin
                            rej_q <= 1'b1;
                        end
                    end else begin
                        rej_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (commit) begin
                sprite_x_q[cur_q.index] <= cur_q.x;
                sprite_y_q[cur_q.index] <= cur_q.y;
            end
        end
    end

    assign sprite_update = sprite_update_q;
    assign update_index  = cur_q.index;
    assign sprite_row    = cur_q.y;
    assign sprite_col    = cur_q.x;
    assign sprite_num    = num_q[cur_q.index];
    assign sprite_x      = sprite_x_q;
    assign sprite_y      = sprite_y_q;

endmodule
